// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU controller and the full-width ALU
// decoder: opcode encodings, the sequencing FSM state type, and a small helper
// that identifies the arithmetic opcodes.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_XOR   = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aluState_e;

    // Only add and subtract produce meaningful carry and overflow flags.
    function automatic logic isArith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/ALU_1bit.sv
// -----------------------------------------------------------------------------
// ALU_1bit
// One-bit ALU cell. Computes a single result bit and carry for the selected
// opcode. Subtraction is realised as a + ~b + cin, so the caller seeds cin=1
// for the LSB of a subtract.
// Ports:
//   a, b  in   operand bits
//   cin   in   carry into this bit
//   ctrl  in   opcode (alu_pkg encodings; unlisted codes give out=0)
//   out   out  result bit
//   cout  out  carry out of this bit (0 for non-arithmetic opcodes)
// -----------------------------------------------------------------------------
module ALU_1bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] ctrl,
    output logic       out,
    output logic       cout
);

    logic bEff;

    // Subtract inverts B so the same full adder serves both arithmetic ops.
    always_comb begin
        bEff = b ^ (ctrl == ALU_SUB);
        out  = 1'b0;
        cout = 1'b0;
        case (ctrl)
            ALU_PASSB: out = b;
            ALU_ADD,
            ALU_SUB: begin
                out  = a ^ bEff ^ cin;
                cout = (a & bEff) | (a & cin) | (bEff & cin);
            end
            ALU_AND:   out = a & b;
            ALU_OR:    out = a | b;
            ALU_XOR:   out = a ^ b;
            default:   out = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// bit_serial_alu_ctrl
// Runs WIDTH-bit ALU operations through a single ALU_1bit cell, one bit per
// clock, LSB first. Operands are captured through a valid/ready handshake,
// the inter-bit carry lives in a flop, and the finished result plus N/Z/V/C
// flags are presented through a second valid/ready handshake.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   operation request
//   in_ready   out  controller can accept (IDLE only)
//   a, b       in   WIDTH-bit operands
//   ctrl       in   3-bit opcode (alu_pkg encodings)
//   out_valid  out  result and flags valid (DONE)
//   out_ready  in   consumer accepts result
//   result     out  WIDTH-bit result
//   negative   out  result MSB
//   zero       out  result == 0
//   overflow   out  signed overflow (add/sub only)
//   carry_out  out  carry from MSB (add/sub only; sub: 1 = no borrow)
// -----------------------------------------------------------------------------
module bit_serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    aluState_e        state_q;
    logic             inReady_q;
    logic             outValid_q;
    logic [WIDTH-1:0] aSh_q;
    logic [WIDTH-1:0] bSh_q;
    logic [WIDTH-2:0] resSh_q;
    logic [WIDTH-1:0] result_q;
    logic [2:0]       ctrl_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             zeroAcc_q;
    logic             negative_q;
    logic             zero_q;
    logic             overflow_q;
    logic             carryOut_q;

    logic             cellOut;
    logic             cellCout;
    logic [WIDTH-1:0] result_d;

    ALU_1bit uCell (
        .a    (aSh_q[0]),
        .b    (bSh_q[0]),
        .cin  (carry_q),
        .ctrl (ctrl_q),
        .out  (cellOut),
        .cout (cellCout)
    );

    // The partial result is kept internal; the cell bit enters at the MSB so
    // after WIDTH shifts the LSB-first stream lands in natural order.
    assign result_d = {cellOut, resSh_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            aSh_q      <= '0;
            bSh_q      <= '0;
            resSh_q    <= '0;
            result_q   <= '0;
            ctrl_q     <= ALU_PASSB;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            zeroAcc_q  <= 1'b0;
            negative_q <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            carryOut_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        aSh_q     <= a;
                        bSh_q     <= b;
                        ctrl_q    <= ctrl;
                        // Subtract is a + ~b + 1: the +1 enters as LSB carry.
                        carry_q   <= (ctrl == ALU_SUB);
                        cnt_q     <= '0;
                        zeroAcc_q <= 1'b1;
                        inReady_q <= 1'b0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    aSh_q     <= aSh_q >> 1;
                    bSh_q     <= bSh_q >> 1;
                    resSh_q   <= result_d[WIDTH-1:1];
                    carry_q   <= cellCout;
                    zeroAcc_q <= zeroAcc_q & ~cellOut;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        // Results become visible only once complete.
                        cnt_q      <= '0;
                        result_q   <= result_d;
                        negative_q <= cellOut;
                        zero_q     <= zeroAcc_q & ~cellOut;
                        // Signed overflow: carry into MSB differs from carry out.
                        if (isArith(ctrl_q)) begin
                            carryOut_q <= cellCout;
                            overflow_q <= carry_q ^ cellCout;
                        end else begin
                            carryOut_q <= 1'b0;
                            overflow_q <= 1'b0;
                        end
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign result    = result_q;
    assign negative  = negative_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign carry_out = carryOut_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_alu_ctrl
// Self-checking bench for bit_serial_alu_ctrl at WIDTH=8. Expected results
// come from a plain-arithmetic reference model of each opcode.
// -----------------------------------------------------------------------------
module tb_bit_serial_alu_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   ctrl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         negative;
    logic         zero;
    logic         overflow;
    logic         carry_out;

    int total;
    int bad;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: whole-word arithmetic on the opcode definitions.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic [2:0] op, output logic [W-1:0] r,
                                  output logic n, output logic z,
                                  output logic v, output logic c);
        logic [W:0] wide;
        r = '0;
        v = 1'b0;
        c = 1'b0;
        case (op)
            3'b000: r = mb;
            3'b010: begin
                wide = {1'b0, ma} + {1'b0, mb};
                r = wide[W-1:0];
                c = wide[W];
                v = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
            end
            3'b011: begin
                wide = {1'b0, ma} + {1'b0, ~mb} + 1;
                r = wide[W-1:0];
                c = wide[W];
                v = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
            end
            3'b100: r = ma & mb;
            3'b101: r = ma | mb;
            3'b110: r = ma ^ mb;
            default: r = '0;
        endcase
        n = r[W-1];
        z = (r == 0);
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkFlags(input string tag, input logic [W-1:0] ea,
                              input logic [W-1:0] eb, input logic [2:0] op);
        logic [W-1:0] r;
        logic n, z, v, c;
        model(ea, eb, op, r, n, z, v, c);
        checkOutput({tag, ".result"}, 32'(result), 32'(r));
        checkOutput({tag, ".neg"}, 32'(negative), 32'(n));
        checkOutput({tag, ".zero"}, 32'(zero), 32'(z));
        checkOutput({tag, ".ovf"}, 32'(overflow), 32'(v));
        checkOutput({tag, ".carry"}, 32'(carry_out), 32'(c));
    endtask

    // One complete operation: request, wait for the result (bounded), hold
    // back-pressure for 'hold' cycles, then handshake. With 'noise' set,
    // in_valid is toggled with junk operands while the op is busy.
    task automatic applyStimulus(input string tag, input logic [W-1:0] sa,
                                 input logic [W-1:0] sb, input logic [2:0] op,
                                 input int hold, input bit noise);
        int lat;
        @(negedge clk);
        a = sa;
        b = sb;
        ctrl = op;
        in_valid = 1'b1;
        out_ready = 1'b0;
        checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        // Accept cycle counts as cycle 0; out_valid appears W+1 cycles later.
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = noise ? 1'($urandom % 2) : 1'b0;
            a = noise ? W'($urandom) : sa;
            b = noise ? W'($urandom) : sb;
            ctrl = noise ? 3'($urandom) : op;
        end while (!out_valid && lat < 40);
        checkOutput({tag, ".latency"}, 32'(lat), 32'(W + 1));
        checkFlags(tag, sa, sb, op);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = noise ? 1'($urandom % 2) : 1'b0;
            a = W'($urandom);
            ctrl = 3'($urandom);
            checkOutput({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
            checkFlags({tag, ".hold"}, sa, sb, op);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, ".post_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] expQ [$];
        int acceptCyc [$];
        int cyc;
        int outs;
        int lastAcc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   rc;
        logic [W-1:0] er;
        logic en, ez, ev, ec;

        total = 0;
        bad = 0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        ctrl = 3'b000;
        reset = 1'b1;
        #12;
        checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst.result", 32'(result), 32'd0);
        checkOutput("rst.flags", 32'({negative, zero, overflow, carry_out}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases from the operation definitions.
        applyStimulus("add7f", 8'h7F, 8'h01, 3'b010, 0, 1'b0);
        applyStimulus("sub55", 8'h05, 8'h05, 3'b011, 0, 1'b0);
        applyStimulus("sub01", 8'h00, 8'h01, 3'b011, 0, 1'b0);
        applyStimulus("and",   8'hF0, 8'h3C, 3'b100, 0, 1'b0);
        applyStimulus("or",    8'hF0, 8'h3C, 3'b101, 0, 1'b0);
        applyStimulus("xor",   8'hF0, 8'h3C, 3'b110, 0, 1'b0);
        applyStimulus("passb", 8'h12, 8'hA5, 3'b000, 0, 1'b0);
        applyStimulus("op111", 8'hFF, 8'hFF, 3'b111, 0, 1'b0);
        applyStimulus("op001", 8'hAA, 8'h55, 3'b001, 0, 1'b0);
        applyStimulus("bp",    8'h9C, 8'h4B, 3'b010, 5, 1'b1);

        // Abort an add partway through RUN with an asynchronous reset.
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        ctrl = 3'b010;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort.out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort.result", 32'(result), 32'd0);
        checkOutput("abort.in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort.flags", 32'({negative, zero, overflow, carry_out}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("post_abort", 8'h01, 8'h01, 3'b010, 0, 1'b0);

        // Randomized operations with random back-pressure and junk requests.
        for (int i = 0; i < 25; i++) begin
            applyStimulus("rand", W'($urandom), W'($urandom), 3'($urandom),
                          int'($urandom_range(0, 3)), 1'($urandom % 2));
        end

        // Back-to-back with both valid and ready held high.
        @(negedge clk);
        ra = W'($urandom);
        rb = W'($urandom);
        rc = 3'b011;
        a = ra;
        b = rb;
        ctrl = rc;
        in_valid = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        outs = 0;
        while ((outs < 3) && (cyc < 100)) begin
            if (out_valid) begin
                checkOutput("b2b.result", 32'(result), 32'(expQ.size() > 0 ? expQ.pop_front() : 8'h00));
                outs++;
            end
            if (in_ready && (acceptCyc.size() < 3)) begin
                acceptCyc.push_back(cyc);
                model(ra, rb, rc, er, en, ez, ev, ec);
                expQ.push_back(er);
                @(negedge clk);
                cyc++;
                ra = W'($urandom);
                rb = W'($urandom);
                rc = (acceptCyc.size() == 1) ? 3'b010 : 3'b110;
                a = ra;
                b = rb;
                ctrl = rc;
                if (acceptCyc.size() == 3) in_valid = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b.outputs", 32'(outs), 32'd3);
        checkOutput("b2b.accepts", 32'(acceptCyc.size()), 32'd3);
        lastAcc = -1;
        foreach (acceptCyc[k]) begin
            if (lastAcc >= 0)
                checkOutput("b2b.spacing", 32'(acceptCyc[k] - lastAcc), 32'(W + 2));
            lastAcc = acceptCyc[k];
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu_ctrl.md
# bit_serial_alu_ctrl

Sequencing controller that runs WIDTH-bit ALU operations through a single one-bit ALU cell, one bit per clock, LSB first. It captures operands and an opcode through a valid/ready handshake, iterates the cell while holding the inter-bit carry in a flop, and assembles the result plus N/Z/V/C flags. It is the area-minimal execution unit for slow paths such as multi-cycle or debug ops, sitting beside the full-width ALU.

## Interface
- WIDTH, 64, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  controller can accept (IDLE only)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ctrl  in  3  opcode: 000 pass B, 010 add, 011 sub (A−B), 100 and, 101 or, 110 xor, 001/111 result 0
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- negative  out  1  result[WIDTH-1]
- zero  out  1  result == 0
- overflow  out  1  signed overflow (add/sub only, else 0)
- carry_out  out  1  carry from MSB (add/sub only, else 0; sub: 1 = no borrow)

## Operation
- FSM states IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid, latch a and b into shift registers and latch ctrl. Set carry flop = 1 if ctrl==011, else 0. Set bit counter = 0, zero-accumulator = 1. Go to RUN.
- RUN: the cell gets a_sh[0], b_sh[0], carry, ctrl.
  - Each cycle: shift a_sh and b_sh right by 1, shift the cell output into result[WIDTH-1] (result shifts right), carry ← cOut, zero_acc ← zero_acc & ~out, counter++.
  - When counter==WIDTH-1: latch carry_out = cOut and overflow = carry_in_msb ^ cOut; go to DONE.
  - For non-add/sub opcodes, carry_out/overflow are forced to 0.
- DONE: out_valid=1. result and all flags are held stable until out_ready=1, then go to IDLE.
- in_valid outside IDLE is ignored (in_ready=0). No bypass: a new op is accepted no earlier than the cycle after the DONE→IDLE handshake.
- The counter is $clog2(WIDTH) bits; it never wraps because RUN exits at WIDTH-1.
- Undefined opcodes 001/111 run the full sequence and produce result 0, zero=1, negative=0.

## Timing
- Reset values (asynchronous):
  - in_ready=1, out_valid=0, result=0.
  - negative=0, zero=0, overflow=0, carry_out=0.
  - State IDLE, carry=0, counter=0.
- Accept at edge T (in_valid&in_ready) → RUN for cycles T+1..T+WIDTH → out_valid=1 after edge T+WIDTH.
- Latency is WIDTH+1 cycles from accept to out_valid.
- Peak throughput: one op per WIDTH+2 cycles with out_ready held high.
- Reset asserted mid-RUN or mid-DONE aborts the op immediately. All outputs return to reset values; no partial result is ever presented.
- out_ready may be high before DONE; it has no effect outside DONE.
- Clock period must exceed the cell's combinational delay, including its gate delays.

## Structure
- Shared package alu_pkg:
  - Opcode constants ALU_PASSB, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR.
  - FSM enum (IDLE, RUN, DONE).
  - Used by this block and the full-width ALU decoder.
- One sub-module instance: the existing one-bit ALU cell ALU_1bit, driven by the shift-register LSBs and the carry flop.
- Everything else (FSM, counter, shift registers, flag logic) lives in bit_serial_alu_ctrl.

## Test plan
All scenarios use WIDTH=8.
- Add 0x7F+0x01, ctrl=010 → result 0x80, negative=1, zero=0, overflow=1, carry_out=0. out_valid rises exactly 9 cycles after accept.
- Sub 0x05−0x05, ctrl=011 → result 0x00, zero=1, carry_out=1, overflow=0. Sub 0x00−0x01 → 0xFF, negative=1, carry_out=0.
- Logic ops on a=0xF0, b=0x3C → and 0x30, or 0xFC, xor 0xCC, all with carry_out=0 and overflow=0. Pass-B with b=0xA5 → 0xA5. ctrl=111 → 0x00 with zero=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → result and flags stable. in_valid pulses during RUN/DONE are ignored. Check in_ready=1 the cycle after the out_ready handshake.
- Reset pulse at RUN bit 3 → out_valid=0, result=0, in_ready=1 immediately. A following add 0x01+0x01 returns 0x02 with no residue from the aborted op.
- Back-to-back: in_valid and out_ready held high for 3 ops → accepts spaced exactly 10 cycles apart, with correct results each.
